// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: run handshake, ROM address/data, branch resolution inputs and decoder-facing outputs.
// Latency: n/a (signal bundle only).
// Backpressure: Stall is the only hold input; there is no ready back to the fetch stage.
//
// Optional feature macro: FETCH_CYCLE_COUNT_EN adds the 16-bit CycleCount signal.
// Modports: master = fetch stage (drives PC/Instr/InstrValid/Done), slave = top level / ROM / decoder side.
interface instr_fetch_if #(
    parameter int PC_W = 10,
    parameter int IW   = 9
);
    // Run control and ROM/decoder inputs to the fetch stage
    logic            Start;
    logic [PC_W-1:0] ProgEnd;
    logic [IW-1:0]   InstrIn;
    logic            Branch;
    logic            Zero;
    logic            Stall;

    // Fetch stage outputs
    logic [PC_W-1:0] PC;
    logic [IW-1:0]   Instr;
    logic            InstrValid;
    logic            Done;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0]     CycleCount;
`endif

`ifdef FETCH_CYCLE_COUNT_EN
    modport master (
        input  Start, ProgEnd, InstrIn, Branch, Zero, Stall,
        output PC, Instr, InstrValid, Done, CycleCount
    );
    modport slave (
        output Start, ProgEnd, InstrIn, Branch, Zero, Stall,
        input  PC, Instr, InstrValid, Done, CycleCount
    );
`else
    modport master (
        input  Start, ProgEnd, InstrIn, Branch, Zero, Stall,
        output PC, Instr, InstrValid, Done
    );
    modport slave (
        output Start, ProgEnd, InstrIn, Branch, Zero, Stall,
        input  PC, Instr, InstrValid, Done
    );
`endif
endinterface

// File: rtl/instr_fetch.sv
// PC / instruction-fetch stage with IDLE/RUN/DONE run sequencing and conditional branch resolution.
// Latency: Start -> first valid instruction 1 cycle; taken branch -> target executes next cycle (no bubble).
// Backpressure: Stall holds PC and state; each stalled cycle re-presents the same instruction.
//
// Ports:
//   Clk        - single clock, all state on rising edge
//   Reset      - synchronous, active-high, overrides every other input
//   bus        - instr_fetch_if.master: Start, ProgEnd, InstrIn, Branch, Zero, Stall in;
//                PC, Instr, InstrValid, Done (and CycleCount) out
// Optional feature macro: FETCH_CYCLE_COUNT_EN adds a saturating 16-bit RUN-cycle counter.
module instr_fetch #(
    parameter int PC_W  = 10,
    parameter int IW    = 9,
    parameter int OFF_W = 6
) (
    input  logic           Clk,
    input  logic           Reset,
    instr_fetch_if.master  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int EXT_W = PC_W - OFF_W;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic            in_run;
    logic            taken;
    logic            at_end;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_br;

    assign in_run = (state_q == ST_RUN);

    // Only a running, non-stalled branch with a non-zero ALU result is taken.
    assign taken  = bus.Branch & ~bus.Zero & in_run & ~bus.Stall;
    assign at_end = (pc_q == bus.ProgEnd);

    // Signed offset field sign-extended to PC width; the adds wrap modulo 2^PC_W,
    // which is exactly the required behaviour in both directions.
    assign br_off = {{EXT_W{bus.InstrIn[OFF_W-1]}}, bus.InstrIn[OFF_W-1:0]};
    assign pc_seq = pc_q + PC_W'(1);
    assign pc_br  = pc_q + br_off;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                // Stall freezes everything, including end-of-program detection.
                if (!bus.Stall) begin
                    if (taken) begin
                        // A taken branch wins over ProgEnd: the run continues.
                        pc_d = pc_br;
                    end else if (at_end) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            ST_DONE: begin
                if (bus.Start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts every RUN cycle (stalls included), saturating; restarts on each accepted Start.
    always_comb begin
        cnt_d = cnt_q;
        if (in_run) begin
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (bus.Start) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.CycleCount = cnt_q;
`endif

    // Outputs come from registered state only; Start has no combinational path to them.
    assign bus.PC         = pc_q;
    assign bus.Instr      = bus.InstrIn;
    assign bus.InstrValid = in_run;
    assign bus.Done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic Clk;
    logic Reset;

    instr_fetch_if #(.PC_W(10), .IW(9)) bus ();

    instr_fetch #(.PC_W(10), .IW(9), .OFF_W(6)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural reference: PC as a plain integer, run/done as two flags.
    int m_pc   = 0;
    bit m_run  = 0;
    bit m_done = 0;
    int m_cnt  = 0;

    typedef struct {
        logic        rst;
        logic        start;
        logic        stall;
        logic        br;
        logic        zero;
        logic [8:0]  instr;
        logic [9:0]  pend;
        int          pc;
        int          vld;
        int          done;
        int          cnt;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic set_in(input logic rst, input logic start, input logic stall,
                          input logic br, input logic zero, input logic [8:0] instr,
                          input logic [9:0] pend);
        Reset       = rst;
        bus.Start   = start;
        bus.Stall   = stall;
        bus.Branch  = br;
        bus.Zero    = zero;
        bus.InstrIn = instr;
        bus.ProgEnd = pend;
    endtask

    // Advance the reference model by one clock using the inputs currently applied.
    task automatic model_step();
        int off;
        if (Reset) begin
            m_pc = 0; m_run = 0; m_done = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (bus.Start) begin
                m_pc = 0; m_run = 1; m_done = 0; m_cnt = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (!bus.Stall) begin
                off = bus.InstrIn[5] ? int'(bus.InstrIn[5:0]) - 64 : int'(bus.InstrIn[5:0]);
                if (bus.Branch && !bus.Zero) m_pc = (m_pc + off + 1024) % 1024;
                else if (m_pc == int'(bus.ProgEnd)) begin m_run = 0; m_done = 1; end
                else m_pc = (m_pc + 1) % 1024;
            end
        end
    endtask

    task automatic check_model();
        chk("pc", int'(bus.PC), m_pc);
        chk("instr_valid", int'(bus.InstrValid), int'(m_run));
        chk("done", int'(bus.Done), int'(m_done));
        chk("instr_pass", int'(bus.Instr), int'(bus.InstrIn));
`ifdef FETCH_CYCLE_COUNT_EN
        chk("cycle_count", int'(bus.CycleCount), m_cnt);
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        check_model();
    endtask

    task automatic plain(input int n, input logic [9:0] pend);
        for (int k = 0; k < n; k++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, pend);
            tick();
        end
    endtask

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3);

        // Basic run with ProgEnd=3, DONE hold, restart from DONE, reset+start mid-run.
        //         rst  start stall br  zero instr   pend   pc vld done cnt
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 0, 0, 0, 0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 0, 1, 0, 0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 1, 1, 0, 1};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 2, 1, 0, 2};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 3, 1, 0, 3};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 3, 0, 1, 4};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h03F, 10'd3, 3, 0, 1, 4};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 0, 1, 0, 0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 1, 1, 0, 1};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 0, 0, 0, 0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd3, 0, 0, 0, 0};

        for (int i = 0; i < 11; i++) begin
            set_in(vt[i].rst, vt[i].start, vt[i].stall, vt[i].br, vt[i].zero,
                   vt[i].instr, vt[i].pend);
            tick();
            chk($sformatf("vec%0d_pc", i), int'(bus.PC), vt[i].pc);
            chk($sformatf("vec%0d_valid", i), int'(bus.InstrValid), vt[i].vld);
            chk($sformatf("vec%0d_done", i), int'(bus.Done), vt[i].done);
`ifdef FETCH_CYCLE_COUNT_EN
            chk($sformatf("vec%0d_cnt", i), int'(bus.CycleCount), vt[i].cnt);
`endif
        end

        // Backward taken branch at PC=5, then same branch not taken (Zero=1),
        // then a taken self-loop at PC==ProgEnd that keeps running.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd6); tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 10'd6); tick();
        plain(5, 10'd6);
        chk("at_pc5", int'(bus.PC), 5);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000111101, 10'd6); tick();
        chk("br_back_taken", int'(bus.PC), 2);
        plain(3, 10'd6);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b000111101, 10'd6); tick();
        chk("br_zero_not_taken", int'(bus.PC), 6);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000000000, 10'd6); tick();
        chk("br_at_end_pc", int'(bus.PC), 6);
        chk("br_at_end_valid", int'(bus.InstrValid), 1);
        plain(1, 10'd6);
        chk("end_after_loop_done", int'(bus.Done), 1);

        // Negative wrap below 0, then sequential wrap at the top of the address space.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd100); tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 10'd100); tick();
        plain(1, 10'd100);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000111110, 10'd100); tick();
        chk("wrap_down", int'(bus.PC), 1023);
        plain(1, 10'd100);
        chk("wrap_up", int'(bus.PC), 0);

        // Two stall cycles on a taken branch at PC=4: PC stays 4 for three cycles.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd100); tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 10'd100); tick();
        plain(4, 10'd100);
        chk("stall_pc_c1", int'(bus.PC), 4);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'b000000011, 10'd100); tick();
        chk("stall_pc_c2", int'(bus.PC), 4);
        tick();
        chk("stall_pc_c3", int'(bus.PC), 4);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000000011, 10'd100); tick();
        chk("stall_then_branch", int'(bus.PC), 7);
`ifdef FETCH_CYCLE_COUNT_EN
        chk("stall_count", int'(bus.CycleCount), 7);
`endif

        // Reset together with Start mid-run at PC=7.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd100); tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 10'd100); tick();
        chk("rst_start_pc", int'(bus.PC), 0);
        chk("rst_start_valid", int'(bus.InstrValid), 0);
        chk("rst_start_done", int'(bus.Done), 0);
        plain(1, 10'd100);
        chk("rst_idle_hold", int'(bus.InstrValid), 0);

`ifdef FETCH_CYCLE_COUNT_EN
        // Counter saturation: a taken self-loop keeps the run alive indefinitely.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 10'd100); tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 10'd100);
        for (int k = 0; k < 65540; k++) begin
            model_step();
            @(posedge Clk);
        end
        #1;
        check_model();
        chk("count_saturated", int'(bus.CycleCount), 65535);
`endif

        // Randomized traffic against the reference model.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 10'd20); tick();
        for (int i = 0; i < 3000; i++) begin
            Reset       = ($urandom_range(0, 63) == 0);
            bus.Start   = ($urandom_range(0, 5) == 0);
            bus.Stall   = ($urandom_range(0, 3) == 0);
            bus.Branch  = ($urandom_range(0, 3) == 0);
            bus.Zero    = 1'($urandom_range(0, 1));
            bus.InstrIn = 9'($urandom);
            if ($urandom_range(0, 15) == 0) bus.ProgEnd = 10'($urandom_range(0, 40));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
